karatsuba_mul_iter: RTL and testbench

KARATSUBA_MUL_ITER -- requirements
Module: karatsuba_mul_iter

---
 rtl/karatsuba_mul_iter.sv | 190 +++++++++++++++++++
 tb/tb_karatsuba_mul_iter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_mul_iter.sv
// Iterative Karatsuba multiplier / multiply-accumulator.
// One shared half-width multiplier pipeline computes the three Karatsuba
// partial products in consecutive cycles. The results are then combined into a
// 2*WIDTH-bit product, which is either stored or added to the previous result.
module karatsuba_mul_iter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_acc,
  input  logic [WIDTH-1:0]     i_x,
  input  logic [WIDTH-1:0]     i_y,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_o,
  output logic                 o_carry
);

  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned PW = 2 * H + 2;   // partial-product width
  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_LO,
    S_ISSUE_HI,
    S_ISSUE_MID,
    S_WAIT,
    S_COMBINE
  } state_t;

  // Identifies which partial product occupies a multiplier pipeline slot.
  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_LO,
    TAG_HI,
    TAG_MID
  } tag_t;

  state_t             r_state;
  state_t             w_next;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_acc;

  logic [H-1:0]       w_a0;
  logic [H-1:0]       w_a1;
  logic [H-1:0]       w_b0;
  logic [H-1:0]       w_b1;

  logic [H:0]         w_op_a;
  logic [H:0]         w_op_b;
  tag_t               w_tag;
  logic [PW-1:0]      w_prod;

  logic [PW-1:0]      r_pp   [MUL_STAGES];
  tag_t               r_ptag [MUL_STAGES];
  logic [PW-1:0]      w_ret;
  tag_t               w_ret_tag;

  logic [2*H-1:0]     r_lo;
  logic [2*H-1:0]     r_hi;
  logic [PW-1:0]      r_midp;

  logic [PW-1:0]      w_mid;
  logic [W2-1:0]      w_p;
  logic [W2:0]        w_sum;

  assign w_a0 = r_a[H-1:0];
  assign w_a1 = r_a[WIDTH-1:H];
  assign w_b0 = r_b[H-1:0];
  assign w_b1 = r_b[WIDTH-1:H];

  assign o_busy = (r_state != S_IDLE);

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. WAIT ends when the MID product leaves the pipeline.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (i_start) w_next = S_ISSUE_LO;
      S_ISSUE_LO:  w_next = S_ISSUE_HI;
      S_ISSUE_HI:  w_next = S_ISSUE_MID;
      S_ISSUE_MID: w_next = S_WAIT;
      S_WAIT:      if (w_ret_tag == TAG_MID) w_next = S_COMBINE;
      S_COMBINE:   w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Capture the operands and the mode on the accepting edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst && r_state == S_IDLE && i_start) begin
      r_a   <= i_x;
      r_b   <= i_y;
      r_acc <= i_acc;
    end
  end

  // Select operands for the shared multiplier according to the issue state.
  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    w_tag  = TAG_NONE;
    case (r_state)
      S_ISSUE_LO: begin
        w_op_a = {1'b0, w_a0};
        w_op_b = {1'b0, w_b0};
        w_tag  = TAG_LO;
      end
      S_ISSUE_HI: begin
        w_op_a = {1'b0, w_a1};
        w_op_b = {1'b0, w_b1};
        w_tag  = TAG_HI;
      end
      S_ISSUE_MID: begin
        w_op_a = {1'b0, w_a0} + {1'b0, w_a1};
        w_op_b = {1'b0, w_b0} + {1'b0, w_b1};
        w_tag  = TAG_MID;
      end
      default: ;
    endcase
  end

  assign w_prod = {{(H+1){1'b0}}, w_op_a} * {{(H+1){1'b0}}, w_op_b};

  // Multiplier pipeline tags. Reset empties every slot, dropping in-flight work.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < MUL_STAGES; i++) r_ptag[i] <= TAG_NONE;
    end else begin
      r_ptag[0] <= w_tag;
      for (int unsigned i = 1; i < MUL_STAGES; i++) r_ptag[i] <= r_ptag[i-1];
    end
  end

  // Multiplier pipeline data. The tags qualify it, so it needs no reset.
  always_ff @(posedge i_clk) begin
    r_pp[0] <= w_prod;
    for (int unsigned i = 1; i < MUL_STAGES; i++) r_pp[i] <= r_pp[i-1];
  end

  assign w_ret     = r_pp[MUL_STAGES-1];
  assign w_ret_tag = r_ptag[MUL_STAGES-1];

  // Collect the returning partial products by tag.
  always_ff @(posedge i_clk) begin
    case (w_ret_tag)
      TAG_LO:  r_lo   <= w_ret[2*H-1:0];
      TAG_HI:  r_hi   <= w_ret[2*H-1:0];
      TAG_MID: r_midp <= w_ret;
      default: ;
    endcase
  end

  // Karatsuba recombination followed by the optional accumulate.
  always_comb begin
    w_mid = r_midp - {2'b00, r_lo} - {2'b00, r_hi};
    w_p   = {{(W2-2*H){1'b0}}, r_lo}
          + ({{(W2-PW){1'b0}}, w_mid} << H)
          + ({{(W2-2*H){1'b0}}, r_hi} << WIDTH);
    w_sum = {1'b0, w_p} + (r_acc ? {1'b0, o_o} : '0);
  end

  // Result registers and the completion pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_o     <= '0;
      o_carry <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= (r_state == S_COMBINE);
      if (r_state == S_COMBINE) begin
        {o_carry, o_o} <= w_sum;
      end
    end
  end

endmodule

// File: tb/tb_karatsuba_mul_iter.sv
// Scoreboard bench for karatsuba_mul_iter: directed checks on an 8-bit
// instance, randomized multiply/accumulate traffic on a 64-bit instance.
module tb_karatsuba_mul_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         start8 = 1'b0, acc8 = 1'b0;
  logic [7:0]   x8 = '0, y8 = '0;
  logic         busy8, done8, carry8;
  logic [15:0]  o8;

  logic         start64 = 1'b0, acc64 = 1'b0;
  logic [63:0]  x64 = '0, y64 = '0;
  logic         busy64, done64, carry64;
  logic [127:0] o64;

  typedef struct {
    logic [128:0] v;
    longint       c;
  } item_t;

  item_t        q8[$];
  item_t        q64[$];
  item_t        it8, it64;
  logic [15:0]  m8  = '0;
  logic [127:0] m64 = '0;

  int           n_tests = 0;
  int           n_fail  = 0;
  longint       cyc     = 0;

  karatsuba_mul_iter #(.WIDTH(8), .MUL_STAGES(2)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .i_acc(acc8),
    .i_x(x8), .i_y(y8), .o_busy(busy8), .o_done(done8),
    .o_o(o8), .o_carry(carry8)
  );

  karatsuba_mul_iter #(.WIDTH(64), .MUL_STAGES(3)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_start(start64), .i_acc(acc64),
    .i_x(x64), .i_y(y64), .o_busy(busy64), .o_done(done64),
    .o_o(o64), .o_carry(carry64)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (!rst && done8) begin
      if (q8.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done8: got o_done=1, expected no result pending (cycle %0d)", cyc);
      end else begin
        it8 = q8.pop_front();
        check("result8", {112'b0, carry8, o8}, it8.v);
        check("latency8", 129'(cyc), 129'(it8.c));
        check("busy_at_done8", 129'(busy8), 129'(0));
      end
    end
  end

  // Monitor for the 64-bit instance.
  always @(negedge clk) begin
    if (!rst && done64) begin
      if (q64.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done64: got o_done=1, expected no result pending (cycle %0d)", cyc);
      end else begin
        it64 = q64.pop_front();
        check("result64", {carry64, o64}, it64.v);
        check("latency64", 129'(cyc), 129'(it64.c));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic a);
    logic [15:0] p;
    logic [16:0] s;
    p  = 16'(x) * 16'(y);
    s  = a ? ({1'b0, m8} + {1'b0, p}) : {1'b0, p};
    m8 = s[15:0];
    q8.push_back('{v: 129'(s), c: cyc + 7});
    x8 = x; y8 = y; acc8 = a; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    x8 = 8'($urandom); y8 = 8'($urandom); acc8 = 1'($urandom);
  endtask

  task automatic issue64(input logic [63:0] x, input logic [63:0] y, input logic a);
    logic [127:0] p;
    logic [128:0] s;
    p   = 128'(x) * 128'(y);
    s   = a ? ({1'b0, m64} + {1'b0, p}) : {1'b0, p};
    m64 = s[127:0];
    q64.push_back('{v: s, c: cyc + 8});
    x64 = x; y64 = y; acc64 = a; start64 = 1'b1;
    tick();
    start64 = 1'b0;
    x64 = {$urandom, $urandom}; y64 = {$urandom, $urandom}; acc64 = 1'($urandom);
  endtask

  task automatic wait_done8();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (done8) seen = 1;
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL timeout_done8: got no o_done in 40 cycles, expected a pulse");
    end
  endtask

  task automatic wait_done64();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (done64) seen = 1;
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL timeout_done64: got no o_done in 40 cycles, expected a pulse");
    end
  endtask

  task automatic wait_empty8();
    for (int i = 0; i < 40 && q8.size() != 0; i++) tick();
    if (q8.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL timeout_empty8: got %0d results outstanding, expected 0", q8.size());
      q8.delete();
    end
  endtask

  task automatic wait_empty64();
    for (int i = 0; i < 40 && q64.size() != 0; i++) tick();
    if (q64.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL timeout_empty64: got %0d results outstanding, expected 0", q64.size());
      q64.delete();
    end
  endtask

  function automatic logic [63:0] pick64();
    case ($urandom_range(0, 9))
      0:       return '0;
      1:       return '1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    check("rst_o8",     129'(o8),     129'(0));
    check("rst_carry8", 129'(carry8), 129'(0));
    check("rst_done8",  129'(done8),  129'(0));
    check("rst_busy8",  129'(busy8),  129'(0));
    check("rst_o64",    129'(o64),    129'(0));
    rst = 1'b0;
    tick();

    // Basic multiply, then accumulate with carry-out.
    issue8(8'hFF, 8'hFF, 1'b0);
    check("busy_after_start8", 129'(busy8), 129'(1));
    wait_empty8();
    check("mul_ff_ff", {112'b0, carry8, o8}, 129'h0FE01);
    issue8(8'hFF, 8'hFF, 1'b1);
    wait_empty8();
    check("acc_ff_ff", {112'b0, carry8, o8}, 129'h1FC02);

    // Start while busy is ignored.
    issue8(8'h12, 8'h34, 1'b0);
    tick();
    x8 = 8'hFF; y8 = 8'hFF; acc8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_empty8();
    repeat (10) tick();
    check("busy_reject", {112'b0, carry8, o8}, 129'h003A8);

    // Reset mid-operation, with a simultaneous start that must be dropped.
    issue8(8'h07, 8'h09, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    x8 = 8'hFF; y8 = 8'hFF; start8 = 1'b1;
    q8.delete();
    m8 = '0;
    m64 = '0;
    tick();
    start8 = 1'b0;
    tick();
    check("midrst_o8",    129'(o8),    129'(0));
    check("midrst_done8", 129'(done8), 129'(0));
    rst = 1'b0;
    repeat (12) tick();
    check("rst_start_dropped", 129'(busy8), 129'(0));
    check("midrst_hold_o8",    129'(o8),    129'(0));
    issue8(8'h03, 8'h05, 1'b1);
    wait_empty8();
    check("acc_after_rst", {112'b0, carry8, o8}, 129'h0000F);

    // Back-to-back: each start lands in the previous o_done cycle.
    issue8(8'hA5, 8'h3C, 1'b0);
    wait_done8();
    issue8(8'h00, 8'hFF, 1'b1);
    wait_done8();
    issue8(8'hFF, 8'hFF, 1'b1);
    wait_done8();
    issue8(8'h80, 8'h02, 1'b0);
    wait_empty8();
    repeat (4) tick();

    // Randomized traffic on the wide instance, mixed gaps and modes.
    for (int n = 0; n < 2000; n++) begin
      issue64(pick64(), pick64(), 1'($urandom));
      wait_done64();
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_empty64();
    repeat (12) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
